// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer placed directly after the UART receiver.
// A byte is captured the cycle after each rx_dv_i pulse. It is stored in a
// circular FIFO and presented first-word-fall-through on a valid/ready port.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   rx_dv_i, rx_data_i   receiver byte-complete pulse; data is valid one cycle later
//   rd_valid_o/ready_i   FWFT read handshake, rd_data_o = oldest byte (0 when empty)
//   level_o              entry count 0..Depth
//   thresh_i/irq_o       level-sensitive irq when level_o >= thresh_i (0 disables)
//   flush_i              synchronous clear of contents and of any pending capture
//   overrun_o/clr_i      sticky drop flag plus saturating drop counter, cleared together
//   drop_cnt_o           number of bytes dropped because the FIFO was full
module uart_rx_fifo #(
    parameter int DataWidth = 8,
    parameter int Depth     = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       rx_dv_i,
    input  logic [DataWidth-1:0]       rx_data_i,
    output logic                       rd_valid_o,
    input  logic                       rd_ready_i,
    output logic [DataWidth-1:0]       rd_data_o,
    output logic [$clog2(Depth):0]     level_o,
    input  logic [$clog2(Depth):0]     thresh_i,
    output logic                       thresh_irq_o,
    input  logic                       flush_i,
    output logic                       overrun_o,
    input  logic                       overrun_clr_i,
    output logic [7:0]                 drop_cnt_o
);

    localparam int AddrWidth = $clog2(Depth);
    localparam logic [AddrWidth:0] FullLvl = (AddrWidth+1)'(Depth);

    logic [DataWidth-1:0] mem [Depth];
    logic [AddrWidth-1:0] wptr_q, rptr_q;
    logic [AddrWidth:0]   level_q;
    logic                 pend_q;
    logic                 overrun_q;
    logic [7:0]           drop_q;

    logic full, pop, wr_en, drop;

    assign full  = (level_q == FullLvl);
    assign pop   = rd_valid_o & rd_ready_i & ~flush_i;
    // When full, a same-cycle pop frees the slot the incoming byte needs.
    assign wr_en = pend_q & ~flush_i & (~full | pop);
    // A byte discarded by flush is not an overrun.
    assign drop  = pend_q & ~flush_i & full & ~pop;

    // Pending flag follows rx_dv_i, so back-to-back pulses each get one sample.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= flush_i ? 1'b0 : rx_dv_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + 1'b1;
            if (pop)   rptr_q <= rptr_q + 1'b1;
            case ({wr_en, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wptr_q] <= rx_data_i;
    end

    // A simultaneous clear and drop leaves the flag set and the count at 1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overrun_q <= 1'b0;
            drop_q    <= '0;
        end else if (drop) begin
            overrun_q <= 1'b1;
            if (overrun_clr_i)       drop_q <= 8'd1;
            else if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end else if (overrun_clr_i) begin
            overrun_q <= 1'b0;
            drop_q    <= '0;
        end
    end

    assign rd_valid_o   = (level_q != '0);
    assign rd_data_o    = rd_valid_o ? mem[rptr_q] : '0;
    assign level_o      = level_q;
    assign thresh_irq_o = (thresh_i != '0) && (level_q >= thresh_i);
    assign overrun_o    = overrun_q;
    assign drop_cnt_o   = drop_q;

endmodule
